// File: rtl/bira_pkg.sv
// Shared types for the built-in redundancy analysis block.
package bira_pkg;

   localparam int ADDR_W = 10;
   localparam int BANK_W = 2;
   localparam int WORD_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_MUST,
      S_GREEDY,
      S_EMIT,
      S_DONE,
      S_FAIL
   } state_t;

   typedef struct packed {
      logic              valid;
      logic              covered;
      logic [BANK_W-1:0] bank;
      logic [ADDR_W-1:0] row;
      logic [ADDR_W-1:0] col;
      logic [WORD_W-1:0] flag;
   } cam_entry_t;

endpackage

// File: rtl/bira_fault_cam.sv
// Fault CAM: merge/allocate reports, per-entry row/col fault counts,
// and bulk cover of all entries sharing a repaired row or column.
module bira_fault_cam
   import bira_pkg::*;
#(
   parameter int N_ENTRY = 16,
   parameter int CW      = $clog2(N_ENTRY) + 1,
   parameter int IW      = $clog2(N_ENTRY)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [ADDR_W-1:0] wr_row,
   input  logic [ADDR_W-1:0] wr_col,
   input  logic [WORD_W-1:0] wr_flag,
   output logic              hit,
   output logic              full,
   output logic [CW-1:0]     cnt,
   input  logic [IW-1:0]     rd_idx,
   output logic              rd_cov,
   output logic [BANK_W-1:0] rd_bank,
   output logic [ADDR_W-1:0] rd_row,
   output logic [ADDR_W-1:0] rd_col,
   output logic [CW-1:0]     row_cnt,
   output logic [CW-1:0]     col_cnt,
   input  logic              cov_en,
   input  logic              cov_row,
   input  logic [BANK_W-1:0] cov_bank,
   input  logic [ADDR_W-1:0] cov_addr
);

   cam_entry_t         mem [N_ENTRY];
   logic [N_ENTRY-1:0] hit_vec;
   cam_entry_t         sel;

   assign sel     = mem[rd_idx];
   assign rd_cov  = sel.covered;
   assign rd_bank = sel.bank;
   assign rd_row  = sel.row;
   assign rd_col  = sel.col;
   assign hit     = |hit_vec;
   assign full    = cnt == CW'(N_ENTRY);

   always_comb begin
      hit_vec = '0;
      for (int j = 0; j < N_ENTRY; j++)
         hit_vec[j] = mem[j].valid && mem[j].bank == wr_bank &&
                      mem[j].row == wr_row && mem[j].col == wr_col;
   end

   // Only still-uncovered faults compete for the remaining spares.
   always_comb begin
      row_cnt = '0;
      col_cnt = '0;
      for (int j = 0; j < N_ENTRY; j++) begin
         if (mem[j].valid && !mem[j].covered && mem[j].bank == sel.bank) begin
            if (mem[j].row == sel.row) row_cnt = row_cnt + CW'(1);
            if (mem[j].col == sel.col) col_cnt = col_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < N_ENTRY; j++) mem[j] <= '0;
         cnt <= '0;
      end else if (clr) begin
         for (int j = 0; j < N_ENTRY; j++) mem[j] <= '0;
         cnt <= '0;
      end else begin
         if (wr_en) begin
            if (hit) begin
               for (int j = 0; j < N_ENTRY; j++)
                  if (hit_vec[j]) mem[j].flag <= mem[j].flag | wr_flag;
            end else if (!full) begin
               mem[cnt[IW-1:0]].valid   <= 1'b1;
               mem[cnt[IW-1:0]].covered <= 1'b0;
               mem[cnt[IW-1:0]].bank    <= wr_bank;
               mem[cnt[IW-1:0]].row     <= wr_row;
               mem[cnt[IW-1:0]].col     <= wr_col;
               mem[cnt[IW-1:0]].flag    <= wr_flag;
               cnt <= cnt + CW'(1);
            end
         end
         if (cov_en) begin
            for (int j = 0; j < N_ENTRY; j++)
               if (mem[j].valid && mem[j].bank == cov_bank &&
                   (cov_row ? mem[j].row : mem[j].col) == cov_addr)
                  mem[j].covered <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/bira_spare_alloc.sv
// Redundancy analysis: collect MBIST faults, must-repair then greedy
// spare allocation per bank, repair commands on a valid/ready stream.
module bira_spare_alloc
   import bira_pkg::*;
#(
   parameter int N_ENTRY   = 16,
   parameter int SPARE_ROW = 2,
   parameter int SPARE_COL = 2,
   parameter int DRAIN_CYC = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     test,
   input  logic                     test_end,
   input  logic                     fault_detect,
   input  logic [1:0]               fault_bank,
   input  logic [9:0]               fault_row,
   input  logic [9:0]               fault_col,
   input  logic [7:0]               fault_col_flag,
   output logic                     early_term,
   output logic                     rep_valid,
   input  logic                     rep_ready,
   output logic                     rep_is_row,
   output logic [1:0]               rep_bank,
   output logic [9:0]               rep_addr,
   output logic                     repair_done,
   output logic                     repair_fail,
   output logic [$clog2(N_ENTRY):0] fault_cnt
);

   localparam int CW = $clog2(N_ENTRY) + 1;
   localparam int IW = $clog2(N_ENTRY);
   localparam int SW = 8;
   localparam int DW = $clog2(DRAIN_CYC + 2);
   localparam int NB = 1 << BANK_W;

   state_t            state;
   state_t            ret_state;
   logic              test_q;
   logic              test_end_q;
   logic              test_rise;
   logic              end_rise;
   logic [CW-1:0]     idx;
   logic [DW-1:0]     drain;
   logic              drain_on;
   logic [SW-1:0]     row_left [NB];
   logic [SW-1:0]     col_left [NB];
   logic              wr_en;
   logic              hit;
   logic              full;
   logic              overflow;
   logic              rd_cov;
   logic [BANK_W-1:0] rd_bank;
   logic [ADDR_W-1:0] rd_row;
   logic [ADDR_W-1:0] rd_col;
   logic [CW-1:0]     row_cnt;
   logic [CW-1:0]     col_cnt;
   logic [SW-1:0]     r_left;
   logic [SW-1:0]     c_left;
   logic              at_end;
   logic              alloc_row;
   logic              alloc_col;
   logic              to_fail;
   logic              cov_en;
   logic [ADDR_W-1:0] cov_addr;

   assign test_rise = test & ~test_q;
   assign end_rise  = test_end & ~test_end_q;
   assign wr_en     = state == S_COLLECT && fault_detect && |fault_col_flag;
   assign overflow  = wr_en & ~hit & full;
   assign at_end    = idx >= fault_cnt;
   assign r_left    = row_left[rd_bank];
   assign c_left    = col_left[rd_bank];
   assign rep_valid = state == S_EMIT;
   assign cov_en    = alloc_row | alloc_col;
   assign cov_addr  = alloc_row ? rd_row : rd_col;

   bira_fault_cam #(.N_ENTRY(N_ENTRY)) u_cam (
      .clk      (clk),
      .rst      (rst),
      .clr      (test_rise),
      .wr_en    (wr_en),
      .wr_bank  (fault_bank),
      .wr_row   (fault_row),
      .wr_col   (fault_col),
      .wr_flag  (fault_col_flag),
      .hit      (hit),
      .full     (full),
      .cnt      (fault_cnt),
      .rd_idx   (idx[IW-1:0]),
      .rd_cov   (rd_cov),
      .rd_bank  (rd_bank),
      .rd_row   (rd_row),
      .rd_col   (rd_col),
      .row_cnt  (row_cnt),
      .col_cnt  (col_cnt),
      .cov_en   (cov_en),
      .cov_row  (alloc_row),
      .cov_bank (rd_bank),
      .cov_addr (cov_addr)
   );

   // A line with more faults than the other spare type can absorb must be
   // replaced whole; the greedy pass then mops up with rows first.
   always_comb begin
      alloc_row = 1'b0;
      alloc_col = 1'b0;
      to_fail   = 1'b0;
      if (!test_rise && !at_end && !rd_cov) begin
         if (state == S_MUST) begin
            if (SW'(row_cnt) > c_left) begin
               if (r_left == '0) to_fail = 1'b1;
               else              alloc_row = 1'b1;
            end else if (SW'(col_cnt) > r_left) begin
               if (c_left == '0) to_fail = 1'b1;
               else              alloc_col = 1'b1;
            end
         end else if (state == S_GREEDY) begin
            if (r_left != '0)      alloc_row = 1'b1;
            else if (c_left != '0) alloc_col = 1'b1;
            else                   to_fail = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ret_state   <= S_IDLE;
         test_q      <= 1'b0;
         test_end_q  <= 1'b0;
         idx         <= '0;
         drain       <= '0;
         drain_on    <= 1'b0;
         for (int b = 0; b < NB; b++) begin
            row_left[b] <= SW'(SPARE_ROW);
            col_left[b] <= SW'(SPARE_COL);
         end
         rep_is_row  <= 1'b0;
         rep_bank    <= '0;
         rep_addr    <= '0;
         repair_done <= 1'b0;
         repair_fail <= 1'b0;
         early_term  <= 1'b0;
      end else begin
         test_q     <= test;
         test_end_q <= test_end;
         early_term <= 1'b0;
         if (test_rise) begin
            state       <= S_COLLECT;
            idx         <= '0;
            drain       <= '0;
            drain_on    <= 1'b0;
            for (int b = 0; b < NB; b++) begin
               row_left[b] <= SW'(SPARE_ROW);
               col_left[b] <= SW'(SPARE_COL);
            end
            repair_done <= 1'b0;
            repair_fail <= 1'b0;
         end else begin
            case (state)
               S_COLLECT: begin
                  if (overflow) begin
                     early_term  <= 1'b1;
                     repair_fail <= 1'b1;
                     state       <= S_FAIL;
                  end else if (drain_on) begin
                     if (drain == '0) begin
                        drain_on <= 1'b0;
                        idx      <= '0;
                        if (fault_cnt == '0 && !wr_en) begin
                           state       <= S_DONE;
                           repair_done <= 1'b1;
                        end else begin
                           state <= S_MUST;
                        end
                     end else begin
                        drain <= drain - DW'(1);
                     end
                  end else if (end_rise) begin
                     drain_on <= 1'b1;
                     drain    <= DW'(DRAIN_CYC);
                  end
               end
               S_MUST, S_GREEDY: begin
                  if (to_fail) begin
                     state       <= S_FAIL;
                     repair_fail <= 1'b1;
                  end else if (cov_en) begin
                     if (alloc_row) row_left[rd_bank] <= r_left - SW'(1);
                     else           col_left[rd_bank] <= c_left - SW'(1);
                     rep_is_row <= alloc_row;
                     rep_bank   <= rd_bank;
                     rep_addr   <= cov_addr;
                     ret_state  <= state;
                     idx        <= idx + CW'(1);
                     state      <= S_EMIT;
                  end else if (at_end) begin
                     idx <= '0;
                     if (state == S_MUST) begin
                        state <= S_GREEDY;
                     end else begin
                        state       <= S_DONE;
                        repair_done <= 1'b1;
                     end
                  end else begin
                     idx <= idx + CW'(1);
                  end
               end
               S_EMIT: begin
                  if (rep_ready) state <= ret_state;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bira_spare_alloc.sv
// Directed bench for bira_spare_alloc with hand-computed repair commands.
module tb_bira_spare_alloc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       test = 1'b0;
   logic       test_end = 1'b0;
   logic       fault_detect = 1'b0;
   logic [1:0] fault_bank = '0;
   logic [9:0] fault_row = '0;
   logic [9:0] fault_col = '0;
   logic [7:0] fault_col_flag = '0;
   logic       early_term;
   logic       rep_valid;
   logic       rep_ready = 1'b1;
   logic       rep_is_row;
   logic [1:0] rep_bank;
   logic [9:0] rep_addr;
   logic       repair_done;
   logic       repair_fail;
   logic [4:0] fault_cnt;

   int errors = 0;
   int checks = 0;
   int et_cnt = 0;
   int rv_seen = 0;
   logic [12:0] cmds [$];

   bira_spare_alloc #(
      .N_ENTRY(16), .SPARE_ROW(2), .SPARE_COL(2), .DRAIN_CYC(2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .test           (test),
      .test_end       (test_end),
      .fault_detect   (fault_detect),
      .fault_bank     (fault_bank),
      .fault_row      (fault_row),
      .fault_col      (fault_col),
      .fault_col_flag (fault_col_flag),
      .early_term     (early_term),
      .rep_valid      (rep_valid),
      .rep_ready      (rep_ready),
      .rep_is_row     (rep_is_row),
      .rep_bank       (rep_bank),
      .rep_addr       (rep_addr),
      .repair_done    (repair_done),
      .repair_fail    (repair_fail),
      .fault_cnt      (fault_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rep_valid && rep_ready) cmds.push_back({rep_is_row, rep_bank, rep_addr});
      if (rep_valid) rv_seen++;
      if (early_term) et_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_test();
      test = 1'b0;
      test_end = 1'b0;
      step();
      cmds.delete();
      et_cnt = 0;
      rv_seen = 0;
      test = 1'b1;
      step();
   endtask

   task automatic send_fault(input logic [1:0] b, input logic [9:0] r,
                             input logic [9:0] c, input logic [7:0] f);
      fault_detect = 1'b1;
      fault_bank = b;
      fault_row = r;
      fault_col = c;
      fault_col_flag = f;
      step();
      fault_detect = 1'b0;
   endtask

   task automatic wait_end();
      int k;
      k = 0;
      while (!(repair_done || repair_fail) && k < 300) begin
         step();
         k++;
      end
      check("finish_bound", 32'(repair_done | repair_fail), 1);
   endtask

   task automatic wait_valid();
      int k;
      k = 0;
      while (!rep_valid && k < 100) begin
         step();
         k++;
      end
      check("valid_bound", 32'(rep_valid), 1);
   endtask

   initial begin
      step();
      step();
      check("rst_valid", 32'(rep_valid), 0);
      check("rst_done", 32'(repair_done), 0);
      check("rst_fail", 32'(repair_fail), 0);
      check("rst_cnt", 32'(fault_cnt), 0);
      check("rst_et", 32'(early_term), 0);
      rst = 1'b0;
      step();

      // single fault: greedy takes a spare row
      start_test();
      send_fault(2'd1, 10'd5, 10'd16, 8'h80);
      test_end = 1'b1;
      wait_end();
      check("t1_ncmd", 32'(cmds.size()), 1);
      check("t1_cmd", 32'(cmds[0]), {1'b1, 2'd1, 10'd5});
      check("t1_done", 32'(repair_done), 1);
      check("t1_fail", 32'(repair_fail), 0);
      check("t1_cnt", 32'(fault_cnt), 1);

      // held report merges into one entry
      start_test();
      fault_detect = 1'b1;
      fault_bank = 2'd2;
      fault_row = 10'd100;
      fault_col = 10'd40;
      fault_col_flag = 8'h01;
      repeat (40) step();
      fault_col_flag = 8'h02;
      step();
      fault_detect = 1'b0;
      check("t2_cnt", 32'(fault_cnt), 1);
      check("t2_flag", 32'(dut.u_cam.mem[0].flag), 8'h03);
      test_end = 1'b1;
      wait_end();
      check("t2_ncmd", 32'(cmds.size()), 1);
      check("t2_cmd", 32'(cmds[0]), {1'b1, 2'd2, 10'd100});
      check("t2_done", 32'(repair_done), 1);

      // must-repair row
      start_test();
      send_fault(2'd1, 10'd7, 10'd0, 8'h01);
      send_fault(2'd1, 10'd7, 10'd8, 8'h04);
      send_fault(2'd1, 10'd7, 10'd16, 8'h10);
      test_end = 1'b1;
      wait_end();
      check("t3_cnt", 32'(fault_cnt), 3);
      check("t3_ncmd", 32'(cmds.size()), 1);
      check("t3_cmd", 32'(cmds[0]), {1'b1, 2'd1, 10'd7});
      check("t3_done", 32'(repair_done), 1);

      // CAM overflow
      start_test();
      for (int i = 0; i < 16; i++) send_fault(2'd3, 10'(i), 10'd0, 8'h01);
      check("t4_full", 32'(fault_cnt), 16);
      check("t4_et_pre", 32'(et_cnt), 0);
      send_fault(2'd3, 10'd16, 10'd0, 8'h01);
      check("t4_et_hi", 32'(early_term), 1);
      step();
      check("t4_et_lo", 32'(early_term), 0);
      repeat (5) step();
      check("t4_et_cnt", 32'(et_cnt), 1);
      check("t4_fail", 32'(repair_fail), 1);
      check("t4_rv", 32'(rv_seen), 0);

      // diagonal faults exhaust spares
      start_test();
      for (int i = 0; i < 5; i++) send_fault(2'd0, 10'(i), 10'(8 * i), 8'h01);
      test_end = 1'b1;
      wait_end();
      check("t5_ncmd", 32'(cmds.size()), 4);
      check("t5_c0", 32'(cmds[0]), {1'b1, 2'd0, 10'd0});
      check("t5_c1", 32'(cmds[1]), {1'b1, 2'd0, 10'd1});
      check("t5_c2", 32'(cmds[2]), {1'b0, 2'd0, 10'd16});
      check("t5_c3", 32'(cmds[3]), {1'b0, 2'd0, 10'd24});
      check("t5_fail", 32'(repair_fail), 1);
      check("t5_done", 32'(repair_done), 0);

      // back-pressure during EMIT
      start_test();
      send_fault(2'd0, 10'd9, 10'd0, 8'h02);
      rep_ready = 1'b0;
      test_end = 1'b1;
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         check("t6_valid", 32'(rep_valid), 1);
         check("t6_cmd", {19'd0, rep_is_row, rep_bank, rep_addr},
               {19'd0, 1'b1, 2'd0, 10'd9});
         step();
      end
      check("t6_none", 32'(cmds.size()), 0);
      rep_ready = 1'b1;
      step();
      wait_end();
      check("t6_ncmd", 32'(cmds.size()), 1);
      check("t6_c0", 32'(cmds[0]), {1'b1, 2'd0, 10'd9});
      check("t6_done", 32'(repair_done), 1);

      // async reset mid-EMIT
      start_test();
      send_fault(2'd2, 10'd11, 10'd0, 8'h01);
      rep_ready = 1'b0;
      test_end = 1'b1;
      wait_valid();
      #3 rst = 1'b1;
      #1;
      check("t7_valid", 32'(rep_valid), 0);
      check("t7_row", 32'(rep_is_row), 0);
      check("t7_addr", 32'(rep_addr), 0);
      check("t7_cnt", 32'(fault_cnt), 0);
      check("t7_done", 32'(repair_done), 0);
      test_end = 1'b0;
      rep_ready = 1'b1;
      #2 rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bira_spare_alloc.md
Name: bira_spare_alloc

Overview:
- Downstream consumer of the MBIST fault outputs.
- Collects fault reports (bank, row, word column, bit flag) into a small fault CAM during test and merges repeated reports.
- After test end, runs must-repair analysis and then greedy spare analysis per bank, and emits repair commands (spare row / spare word-column) over a valid/ready stream.
- Drives early_term back to the MBIST when the CAM overflows.

Parameters:
- N_ENTRY, 16, fault CAM depth (power of 2, 4..32)
- SPARE_ROW, 2, spare rows per bank
- SPARE_COL, 2, spare word-columns (8-bit wide) per bank
- DRAIN_CYC, 2, cycles after test_end rise during which faults are still accepted (MBIST read-compare latency)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- test  in  1  rising edge clears state and starts collection
- test_end  in  1  MBIST terminated (level)
- fault_detect  in  1  fault report valid (may stay high with repeated content)
- fault_bank  in  2  faulty bank address
- fault_row  in  10  faulty row
- fault_col  in  10  faulty word column (multiple of 8)
- fault_col_flag  in  8  faulty bit positions within the word
- early_term  out  1  one-cycle pulse on CAM overflow
- rep_valid  out  1  repair command valid
- rep_ready  in  1  consumer accepts command
- rep_is_row  out  1  1: spare row, 0: spare column
- rep_bank  out  2  bank of the repair
- rep_addr  out  10  row address or word-column address
- repair_done  out  1  analysis finished, all faults covered (sticky)
- repair_fail  out  1  unrepairable or overflow (sticky)
- fault_cnt  out  $clog2(N_ENTRY)+1  valid CAM entries

Behaviour:
- Reset (async): all outputs 0; state IDLE; CAM invalid; per-bank spare counters loaded to SPARE_ROW / SPARE_COL.
- Rising edge of test (registered edge detect), in any state except mid-reset: clear CAM, covered bits, counters, done and fail; go to COLLECT.
- Entry fields: valid, covered, bank, row, col, flag.
- COLLECT, each cycle with fault_detect=1 and fault_col_flag != 0:
  - CAM hit on {bank, row, col}: flag |= fault_col_flag.
  - Miss and not full: write entry at index fault_cnt; fault_cnt+1 next cycle.
  - Miss and full: early_term=1 for exactly one cycle, repair_fail=1, go to FAIL.
- A report in the same cycle as test_end rising is processed normally.
- test_end rise starts a DRAIN_CYC down-counter while still collecting. At 0: go to MUST with index i=0. If fault_cnt=0, go directly to DONE.
- Combinational per entry i, over valid & !covered entries:
  - row_cnt[i] = count of entries with the same bank and row.
  - col_cnt[i] = count of entries with the same bank and col.
- MUST, one entry per cycle, i = 0..fault_cnt-1; entries that are covered are skipped (1 cycle):
  - row_cnt[i] > spare_col_left[bank]: need a spare row. If spare_row_left = 0, go to FAIL; else allocate the row.
  - else if col_cnt[i] > spare_row_left[bank]: need a spare column. If spare_col_left = 0, go to FAIL; else allocate the column.
  - else: skip.
- Allocating a row/column: decrement the bank counter, set covered on all matching entries, load the rep_* registers, go to EMIT.
- EMIT: rep_valid=1; the command stays stable until rep_valid&rep_ready; then return to the calling pass with i+1.
- After the last i, MUST goes to GREEDY with i=0.
- GREEDY, each uncovered entry in turn:
  - spare row left: allocate a row.
  - else spare column left: allocate a column.
  - else: go to FAIL.
- After the last i, go to DONE.
- DONE: repair_done=1. FAIL: repair_fail=1, rep_valid=0. Both hold until test rise or rst.
- test rise during EMIT drops rep_valid the next cycle with no handshake completed.
- fault_detect outside COLLECT is ignored.
- Counters never underflow; a zero counter blocks allocation as specified.

Decomposition:
- Shared package bira_pkg: state enum (IDLE, COLLECT, MUST, GREEDY, EMIT, DONE, FAIL), CAM entry struct, ADDR_W=10, BANK_W=2, WORD_W=8.
- One sub-module, bira_fault_cam: storage, hit/alloc, row_cnt/col_cnt generation, cover-by-row/col.

Test Plan:
- Single fault at bank 01, row 5, col 16, flag 0x80, then test_end -> after DRAIN_CYC+MUST+GREEDY: one command {row=1, bank 01, addr 5}; repair_done=1; fault_cnt=1.
- fault_detect held 40 cycles with identical content 0x01, then 0x02 at the same address -> fault_cnt=1, flag=0x03, a single repair command.
- Three faults in row 7, bank 01, cols 0/8/16, SPARE_COL=2 -> MUST emits row 7 first; no column commands; repair_done=1.
- 17 distinct faults with N_ENTRY=16 -> early_term high exactly 1 cycle on the 17th; repair_fail=1; no rep_valid.
- 5 diagonal faults in one bank with 2+2 spares -> 4 commands (2 rows, 2 columns), then repair_fail=1.
- rep_ready held 0 for 10 cycles during EMIT -> rep_* stable the whole time; the command is issued once after ready rises. Asserting rst mid-EMIT clears all outputs asynchronously.
